// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART: serial input toward the receiver,
// recovered byte and status pulses back toward the command/loopback logic.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    // Receiver side: consumes the line, produces the byte and status.
    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output parity_error,
        output framing_error,
        output busy
    );

    // Line/consumer side: drives the line, observes the byte and status.
    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  parity_error,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even parity, 1 stop bit.
// The async line is double-flopped, the start bit is confirmed at mid-bit,
// and every later bit is sampled one full bit period after the previous one.
module uart_rx #(
    parameter int BIT_TIMING = 5208,
    parameter int PARITY_EN  = 0
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(BIT_TIMING);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_TIMING / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(BIT_TIMING - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic          sync1_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    // Even parity: data plus parity bit must hold an even number of ones.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Next-state logic; status pulses default low so each lasts one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + ONE;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        perr_d  = (PARITY_EN != 0) && parity_bad(shift_q, par_q);
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, synchroniser and outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= bus.rx;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Assembly registers; only read after being fully written by a frame.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_valid      = valid_q;
    assign bus.parity_error  = perr_q;
    assign bus.framing_error = ferr_q;
    assign bus.busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one receiver without parity, one with even parity,
// both at 16 clocks per bit. Expected status events are queued when a frame
// is launched and popped when a receiver raises a pulse.
module tb_uart_rx;
    localparam int BT = 16;

    typedef struct packed {
        logic        v;
        logic        fe;
        logic        pe;
        logic [7:0]  d;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cyc = 32'd0;
    int          total = 0;
    int          bad = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    uart_rx_if if0();
    uart_rx_if if1();

    uart_rx #(.BIT_TIMING(BT), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    uart_rx #(.BIT_TIMING(BT), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic on_event(input int which, input logic v, input logic fe,
                            input logic pe, input logic [7:0] d);
        exp_t e;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_pulse%0d", which), 32'({v, fe, pe}), 32'd0);
        end else begin
            if (which == 0) e = q0.pop_front();
            else            e = q1.pop_front();
            check($sformatf("pulses%0d", which), 32'({v, fe, pe}), 32'({e.v, e.fe, e.pe}));
            check($sformatf("latency%0d", which), cyc, e.cyc);
            if (e.v) check($sformatf("rx_data%0d", which), 32'(d), 32'(e.d));
        end
    endtask

    // Scoreboard side: any status pulse must match the head of its queue.
    always @(negedge clk) begin
        if (if0.rx_valid === 1'b1 || if0.framing_error === 1'b1 || if0.parity_error === 1'b1)
            on_event(0, if0.rx_valid, if0.framing_error, if0.parity_error, if0.rx_data);
        if (if1.rx_valid === 1'b1 || if1.framing_error === 1'b1 || if1.parity_error === 1'b1)
            on_event(1, if1.rx_valid, if1.framing_error, if1.parity_error, if1.rx_data);
    end

    task automatic set_line(input int which, input logic b);
        if (which == 0) if0.rx = b;
        else            if1.rx = b;
    endtask

    task automatic hold_bit(input int which, input logic b);
        set_line(which, b);
        repeat (BT) @(posedge clk);
        #1;
    endtask

    // Launch one frame starting just after a rising edge. The start bit is
    // confirmed 11 edges later (2 sync + 1 IDLE + 8 half-bit), each data bit
    // adds 16, parity adds 16, stop adds 16 -> pulse 155 (171) edges later.
    task automatic send(input int which, input logic [7:0] d, input logic stop,
                        input logic has_par, input logic par, input logic expect_evt);
        exp_t e;
        @(posedge clk);
        #1;
        e.v   = stop;
        e.fe  = ~stop;
        e.pe  = stop & has_par & (^{d, par});
        e.d   = d;
        e.cyc = cyc + (has_par ? 32'd171 : 32'd155);
        if (expect_evt) begin
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        hold_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(which, d[i]);
        if (has_par) hold_bit(which, par);
        hold_bit(which, stop);
        set_line(which, 1'b1);
        repeat (40) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with the line low, then release with the line idle
        reset  = 1'b0;
        if0.rx = 1'b0;
        if1.rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", 32'(if0.rx_data), 32'h00);
        check("rst_rx_valid", 32'(if0.rx_valid), 32'd0);
        check("rst_parity_error", 32'(if0.parity_error), 32'd0);
        check("rst_framing_error", 32'(if0.framing_error), 32'd0);
        check("rst_busy0", 32'(if0.busy), 32'd0);
        check("rst_busy1", 32'(if1.busy), 32'd0);
        if0.rx = 1'b1;
        if1.rx = 1'b1;
        reset  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_busy0", 32'(if0.busy), 32'd0);
        check("idle_busy1", 32'(if1.busy), 32'd0);

        // 2: clean 8N1 frame
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        check("drain_a5", 32'(q0.size()), 32'd0);
        check("hold_a5", 32'(if0.rx_data), 32'hA5);

        // 3: 5-cycle glitch aborts in START
        @(posedge clk);
        #1;
        if0.rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        if0.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("glitch_busy_hi", 32'(if0.busy), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy_lo", 32'(if0.busy), 32'd0);
        check("glitch_rx_data", 32'(if0.rx_data), 32'hA5);

        // 4: stop bit low -> framing error, byte not taken
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        check("drain_3c", 32'(q0.size()), 32'd0);
        check("ferr_rx_data", 32'(if0.rx_data), 32'hA5);
        check("ferr_busy", 32'(if0.busy), 32'd0);

        // 5: even parity, correct then wrong parity bit
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        send(1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
        check("drain_par", 32'(q1.size()), 32'd0);
        check("par_rx_data", 32'(if1.rx_data), 32'h07);

        // 6: reset in the middle of bit 4 of 8'hFF, then a clean frame
        fork
            send(0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                repeat (BT * 5 + 8) @(posedge clk);
                #1;
                reset = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("midrst_busy", 32'(if0.busy), 32'd0);
                check("midrst_rx_data", 32'(if0.rx_data), 32'h00);
                reset = 1'b1;
            end
        join
        check("midrst_quiet", 32'(q0.size()), 32'd0);
        send(0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        check("drain_55", 32'(q0.size()), 32'd0);
        check("hold_55", 32'(if0.rx_data), 32'h55);

        repeat (20) @(posedge clk);
        #1;
        check("final_q0", 32'(q0.size()), 32'd0);
        check("final_q1", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
